// File: rtl/rgb_spike_encoder_pkg.sv
// Shared definitions for the RGB spike encoder: the encoder FSM states,
// the default channel/window constants shared with the neuron layer, and
// a helper that sizes the step counter.
package rgb_spike_encoder_pkg;

  // Encoder window phases, in the order they occur for one pixel.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NRST  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } enc_state_t;

  localparam int DEF_NUM_CH    = 7;
  localparam int DEF_VAL_W     = 8;
  localparam int DEF_WINDOW    = 64;
  localparam int DEF_DRAIN_CYC = 6;

  // One counter serves both RUN and DRAIN, so it must hold the larger
  // of the two terminal counts.
  function automatic int step_cnt_w(input int window, input int drain);
    int m;
    m = (window > drain) ? window : drain;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rgb_spike_encoder_if.sv
// Pixel-in / spike-out bundle of the encoder.
//
// Handshake: a pixel moves on a rising clk edge where in_valid and in_ready
// are both high. The source holds in_data stable while in_valid is high and
// not yet accepted; in_ready never depends on in_valid.
interface rgb_spike_encoder_if #(
  parameter int NUM_CH = 7,
  parameter int VAL_W  = 8
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CH*VAL_W-1:0] in_data;
  logic [NUM_CH-1:0]       spike;
  logic                    neuron_reset;
  logic                    busy;
  logic                    window_done;

  // Pixel source / spike consumer side.
  modport master (
    output in_valid, in_data,
    input  in_ready, spike, neuron_reset, busy, window_done
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, spike, neuron_reset, busy, window_done
  );
endinterface

// File: rtl/rgb_spike_encoder_channel.sv
// One rate-coding channel: a VAL_W-bit phase accumulator whose carry-out,
// registered, is the spike. Wrap-around of the accumulator is the mechanism
// that spreads spikes evenly across the window.
module spike_rate_channel #(
  parameter int VAL_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             step,
  input  logic [VAL_W-1:0] val,
  output logic             spike
);
  logic [VAL_W-1:0] acc_q;
  logic [VAL_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, val};

  // Clear wins; otherwise advance the phase on step, and emit no spike when idle.
  always_ff @(posedge clk) begin
    if (clear) begin
      acc_q <= '0;
      spike <= 1'b0;
    end else if (step) begin
      acc_q <= sum[VAL_W-1:0];
      spike <= sum[VAL_W];
    end else begin
      spike <= 1'b0;
    end
  end
endmodule

// File: rtl/rgb_spike_encoder.sv
// Rate-codes one pixel feature vector into NUM_CH spike trains over WINDOW
// timesteps, framed by a neuron_reset pulse before and DRAIN_CYC quiet
// cycles plus a window_done strobe after.
//
// The accumulators are cleared on the accept edge and take their first
// step during the NRST cycle, so the registered spikes line up exactly with
// the WINDOW RUN cycles; the last RUN cycle does not step, which returns
// spike to 0 right after the window.
module rgb_spike_encoder
  import rgb_spike_encoder_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int VAL_W     = DEF_VAL_W,
  parameter int WINDOW    = DEF_WINDOW,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
  input  logic                 clk,
  input  logic                 reset,
  rgb_spike_encoder_if.slave   bus,
  output enc_state_t           state_dbg
);
  localparam int CNT_W = step_cnt_w(WINDOW, DRAIN_CYC);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = (DRAIN_CYC > 0) ? CNT_W'(DRAIN_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  enc_state_t              state_q;
  logic [CNT_W-1:0]        step_cnt_q;
  logic [NUM_CH*VAL_W-1:0] val_q;
  logic                    neuron_reset_q;
  logic                    busy_q;
  logic                    window_done_q;
  logic [NUM_CH-1:0]       spike_w;

  logic accept;
  logic run_last;
  logic ch_clear;
  logic ch_step;

  assign accept   = (state_q == IDLE) && bus.in_valid && !reset;
  assign run_last = (step_cnt_q == RUN_LAST);
  assign ch_clear = reset || accept;
  assign ch_step  = (state_q == NRST) || ((state_q == RUN) && !run_last);

  assign bus.in_ready     = (state_q == IDLE) && !reset;
  assign bus.neuron_reset = neuron_reset_q;
  assign bus.busy         = busy_q;
  assign bus.window_done  = window_done_q;
  assign bus.spike        = spike_w;
  assign state_dbg        = state_q;

  // Window sequencer: phase, shared step counter, pixel latch and framing strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      step_cnt_q     <= '0;
      val_q          <= '0;
      neuron_reset_q <= 1'b0;
      busy_q         <= 1'b0;
      window_done_q  <= 1'b0;
    end else begin
      neuron_reset_q <= 1'b0;
      window_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            val_q          <= bus.in_data;
            step_cnt_q     <= '0;
            neuron_reset_q <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= NRST;
          end
        end
        NRST: begin
          step_cnt_q <= '0;
          state_q    <= RUN;
        end
        RUN: begin
          if (run_last) begin
            step_cnt_q <= '0;
            if (DRAIN_CYC == 0) begin
              window_done_q <= 1'b1;
              state_q       <= DONE;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            step_cnt_q <= step_cnt_q + CNT_ONE;
          end
        end
        DRAIN: begin
          if (step_cnt_q == DRAIN_LAST) begin
            step_cnt_q    <= '0;
            window_done_q <= 1'b1;
            state_q       <= DONE;
          end else begin
            step_cnt_q <= step_cnt_q + CNT_ONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // One phase accumulator per channel, all stepped in lockstep.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    spike_rate_channel #(.VAL_W(VAL_W)) u_ch (
      .clk   (clk),
      .clear (ch_clear),
      .step  (ch_step),
      .val   (val_q[i*VAL_W +: VAL_W]),
      .spike (spike_w[i])
    );
  end
endmodule

// File: tb/tb_rgb_spike_encoder.sv
// Bench for rgb_spike_encoder: three instances (64/6, 256/6, 1/0 window/drain)
// driven one at a time, checked every cycle against a timeline model and a
// per-window spike-count scoreboard.
module tb_rgb_spike_encoder;
  import rgb_spike_encoder_pkg::*;

  localparam int NC = 7;
  localparam int VW = 8;
  localparam int DW = NC * VW;
  localparam int CW = NC * 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]          rst;
  logic [2:0]          vld;
  logic [2:0][DW-1:0]  dat;
  logic [2:0]          rdy, nrst, busy, done;
  logic [2:0][NC-1:0]  spk;
  enc_state_t          st_a, st_b, st_c;

  rgb_spike_encoder_if #(.NUM_CH(NC), .VAL_W(VW)) bus_a ();
  rgb_spike_encoder_if #(.NUM_CH(NC), .VAL_W(VW)) bus_b ();
  rgb_spike_encoder_if #(.NUM_CH(NC), .VAL_W(VW)) bus_c ();

  assign bus_a.in_valid = vld[0];  assign bus_a.in_data = dat[0];
  assign bus_b.in_valid = vld[1];  assign bus_b.in_data = dat[1];
  assign bus_c.in_valid = vld[2];  assign bus_c.in_data = dat[2];
  assign rdy[0] = bus_a.in_ready;  assign nrst[0] = bus_a.neuron_reset;
  assign busy[0] = bus_a.busy;     assign done[0] = bus_a.window_done;  assign spk[0] = bus_a.spike;
  assign rdy[1] = bus_b.in_ready;  assign nrst[1] = bus_b.neuron_reset;
  assign busy[1] = bus_b.busy;     assign done[1] = bus_b.window_done;  assign spk[1] = bus_b.spike;
  assign rdy[2] = bus_c.in_ready;  assign nrst[2] = bus_c.neuron_reset;
  assign busy[2] = bus_c.busy;     assign done[2] = bus_c.window_done;  assign spk[2] = bus_c.spike;

  rgb_spike_encoder #(.NUM_CH(NC), .VAL_W(VW), .WINDOW(64), .DRAIN_CYC(6)) dut_a (
    .clk(clk), .reset(rst[0]), .bus(bus_a.slave), .state_dbg(st_a));
  rgb_spike_encoder #(.NUM_CH(NC), .VAL_W(VW), .WINDOW(256), .DRAIN_CYC(6)) dut_b (
    .clk(clk), .reset(rst[1]), .bus(bus_b.slave), .state_dbg(st_b));
  rgb_spike_encoder #(.NUM_CH(NC), .VAL_W(VW), .WINDOW(1), .DRAIN_CYC(0)) dut_c (
    .clk(clk), .reset(rst[2]), .bus(bus_c.slave), .state_dbg(st_c));

  function automatic int win_of(input int s);
    return (s == 0) ? 64 : (s == 1) ? 256 : 1;
  endfunction
  function automatic int drn_of(input int s);
    return (s == 2) ? 0 : 6;
  endfunction

  // Number of carries in timestep j (1-based) for intensity v.
  function automatic int exp_sp(input int v, input int j);
    return (v * j) / 256 - (v * (j - 1)) / 256;
  endfunction

  // ---------------- model / scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int acc_k[3];
  logic [DW-1:0] pix[3];
  int obs[3][NC];
  int last_cnt[3][NC];
  int first1[3];
  int nrst_cyc[3];
  int done_cyc[3];
  int done_n[3];
  logic [CW+1:0] exp_q[$];   // {dut tag, packed 9-bit expected counts}

  function automatic int pending(input int s);
    int n;
    n = 0;
    foreach (exp_q[i]) if (exp_q[i][CW+1:CW] == 2'(s)) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int s = 0; s < 3; s++) begin
        int w, d, k, v, j, fidx;
        bit act, e_rdy, e_nr, e_busy, e_done;
        logic [NC-1:0] es;
        logic [CW-1:0] got_cnt, e_cnt;
        w = win_of(s); d = drn_of(s); k = acc_k[s];
        act = (k >= 0) && (cyc <= k + 2 + w + d);
        j = cyc - k - 1;
        es = '0;
        for (int ch = 0; ch < NC; ch++) begin
          v = int'(pix[s][ch*VW +: VW]);
          if (act && j >= 1 && j <= w) es[ch] = (exp_sp(v, j) != 0);
        end
        e_rdy  = !rst[s] && !act;
        e_nr   = act && (cyc == k + 1);
        e_busy = act && (cyc >= k + 1);
        e_done = act && (cyc == k + 2 + w + d);
        checks++;
        if ({rdy[s], nrst[s], busy[s], done[s], spk[s]} !== {e_rdy, e_nr, e_busy, e_done, es}) begin
          failures++;
          $display("FAIL outputs dut%0d cyc=%0d got rdy=%b nrst=%b busy=%b done=%b spike=%b want rdy=%b nrst=%b busy=%b done=%b spike=%b",
                   s, cyc, rdy[s], nrst[s], busy[s], done[s], spk[s], e_rdy, e_nr, e_busy, e_done, es);
        end
        // observations from the DUT
        for (int ch = 0; ch < NC; ch++) obs[s][ch] += int'(spk[s][ch] === 1'b1);
        if (spk[s][1] === 1'b1 && first1[s] < 0) first1[s] = cyc;
        if (nrst[s] === 1'b1) nrst_cyc[s] = cyc;
        if (done[s] === 1'b1) begin
          done_cyc[s] = cyc;
          done_n[s]++;
          for (int ch = 0; ch < NC; ch++) begin
            got_cnt[ch*9 +: 9] = 9'(obs[s][ch]);
            last_cnt[s][ch] = obs[s][ch];
          end
          fidx = -1;
          foreach (exp_q[i]) if (fidx < 0 && exp_q[i][CW+1:CW] == 2'(s)) fidx = i;
          checks++;
          if (fidx < 0) begin
            failures++;
            $display("FAIL done_unexpected dut%0d cyc=%0d got window_done=1 want no pending window", s, cyc);
          end else begin
            e_cnt = exp_q[fidx][CW-1:0];
            exp_q.delete(fidx);
            if (got_cnt !== e_cnt) begin
              failures++;
              $display("FAIL spike_counts dut%0d cyc=%0d got=%h want=%h", s, cyc, got_cnt, e_cnt);
            end
          end
        end
        // model update for the closing edge of this cycle
        if (rst[s]) begin
          acc_k[s] = -1;
          for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i][CW+1:CW] == 2'(s)) exp_q.delete(i);
        end else if (e_rdy && vld[s]) begin
          acc_k[s] = cyc;
          pix[s] = dat[s];
          for (int ch = 0; ch < NC; ch++) begin
            e_cnt[ch*9 +: 9] = 9'((int'(dat[s][ch*VW +: VW]) * w) / 256);
            obs[s][ch] = 0;
          end
          exp_q.push_back({2'(s), e_cnt});
          first1[s] = -1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] mk(input int c0, c1, c2, c3, c4, c5, c6);
    logic [DW-1:0] p;
    p = {8'(c6), 8'(c5), 8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    return p;
  endfunction

  function automatic logic [DW-1:0] rand_pix();
    logic [DW-1:0] p;
    int r;
    for (int ch = 0; ch < NC; ch++) begin
      r = $urandom_range(0, 9);
      p[ch*VW +: VW] = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 255));
    end
    return p;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
  task automatic send(input int s, input logic [DW-1:0] d, input bit keep, output int k);
    int n;
    dat[s] = d; vld[s] = 1'b1; n = 0; k = -1;
    while (k < 0 && n < 2000) begin
      @(negedge clk); #1;
      if (rdy[s] === 1'b1) k = cyc;
      n++;
    end
    @(posedge clk); #1;
    if (!keep || k < 0) vld[s] = 1'b0;
    if (k < 0) begin
      checks++; failures++;
      $display("FAIL accept_timeout dut%0d got no in_ready want accept within 2000 cycles", s);
    end
  endtask

  task automatic wait_done(input int s, input int budget);
    int n0, n;
    n0 = done_n[s]; n = 0;
    while (done_n[s] == n0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    if (done_n[s] == n0) begin
      checks++; failures++;
      $display("FAIL done_timeout dut%0d got no window_done want one within %0d cycles", s, budget);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, k2, dn, sum;
    logic [DW-1:0] p;
    rst = 3'b111; vld = 3'b000; dat = '0;
    for (int s = 0; s < 3; s++) begin
      acc_k[s] = -1; first1[s] = -1; nrst_cyc[s] = -1; done_cyc[s] = -1; done_n[s] = 0;
      for (int ch = 0; ch < NC; ch++) begin obs[s][ch] = 0; last_cnt[s][ch] = 0; end
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk); #1;
    chk("reset_in_ready", 64'(rdy), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_spike_a", 64'(spk[0]), 64'd0);
    idle(1);
    rst = 3'b000;
    @(negedge clk); #1;
    chk("ready_after_reset", 64'(rdy), 64'd7);
    idle(1);

    // 1: all-zero pixel
    send(0, '0, 1'b0, k);
    wait_done(0, 200);
    chk("t1_nrst_cyc", 64'(nrst_cyc[0]), 64'(k + 1));
    chk("t1_done_cyc", 64'(done_cyc[0]), 64'(k + 72));
    sum = 0;
    for (int ch = 0; ch < NC; ch++) sum += last_cnt[0][ch];
    chk("t1_zero_spikes", 64'(sum), 64'd0);
    @(negedge clk); #1;
    chk("t1_ready_cyc", 64'(cyc), 64'(k + 73));
    chk("t1_ready", 64'(rdy[0]), 64'd1);
    idle(2);

    // 2: fixed intensities
    send(0, mk(255, 128, 4, 3, 64, 0, 0), 1'b0, k);
    wait_done(0, 200);
    chk("t2_ch0", 64'(last_cnt[0][0]), 64'd63);
    chk("t2_ch1", 64'(last_cnt[0][1]), 64'd32);
    chk("t2_ch2", 64'(last_cnt[0][2]), 64'd1);
    chk("t2_ch3", 64'(last_cnt[0][3]), 64'd0);
    chk("t2_ch4", 64'(last_cnt[0][4]), 64'd16);
    chk("t2_ch1_first", 64'(first1[0]), 64'(k + 3));
    idle(3);

    // 3: two queued pixels with in_valid held high
    send(0, rand_pix(), 1'b1, k);
    send(0, rand_pix(), 1'b0, k2);
    chk("t3_second_accept", 64'(k2), 64'(k + 73));
    wait_done(0, 200);
    idle(2);

    // 4: reset mid-RUN, then a clean pixel
    send(0, mk(200, 17, 255, 90, 1, 128, 77), 1'b0, k);
    idle(29);
    rst[0] = 1'b1;
    dn = done_n[0];
    idle(1);
    rst[0] = 1'b0;
    @(negedge clk); #1;
    chk("t4_busy_cleared", 64'(busy[0]), 64'd0);
    chk("t4_spike_cleared", 64'(spk[0]), 64'd0);
    idle(80);
    chk("t4_no_done", 64'(done_n[0]), 64'(dn));
    send(0, mk(255, 0, 0, 0, 0, 0, 0), 1'b0, k);
    wait_done(0, 200);
    chk("t4_ch0_after_reset", 64'(last_cnt[0][0]), 64'd63);
    idle(2);

    // random pixels with random gaps and held valids
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 3));
      send(0, rand_pix(), 1'($urandom_range(0, 1)), k);
    end
    vld[0] = 1'b0;
    idle(250);
    chk("rand_a_drained", 64'(pending(0)), 64'd0);

    // 5: WINDOW=256, 100 random back-to-back pixels
    for (int i = 0; i < 100; i++) begin
      p = rand_pix();
      send(1, p, (i != 99), k);
    end
    wait_done(1, 400);
    for (int ch = 0; ch < NC; ch++) chk("t5_last_count", 64'(last_cnt[1][ch]), 64'(p[ch*VW +: VW]));
    chk("t5_drained", 64'(pending(1)), 64'd0);

    // 6: WINDOW=1, no drain
    send(2, mk(255, 0, 0, 0, 0, 0, 0), 1'b0, k);
    @(negedge clk); #1;
    chk("t6_nrst_k1", 64'(nrst[2]), 64'd1);
    idle(1);
    @(negedge clk); #1;
    chk("t6_spike_k2", 64'(spk[2]), 64'd0);
    chk("t6_busy_k2", 64'(busy[2]), 64'd1);
    idle(1);
    @(negedge clk); #1;
    chk("t6_done_k3", 64'(done[2]), 64'd1);
    chk("t6_done_cyc", 64'(cyc), 64'(k + 3));
    idle(1);
    @(negedge clk); #1;
    chk("t6_ready_k4", 64'(rdy[2]), 64'd1);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #3000000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
